nm_pkt_rx: RTL and testbench

NM_PKT_RX -- requirements
Module: nm_pkt_rx

---
 rtl/nm_pkt_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_nm_pkt_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nm_pkt_rx.sv
// Serial packet receiver for the NM model return channel.
// Grants a transmission, hunts for sync, then checks the CRC-8 over type/hdr/payload.
module nm_pkt_rx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        tx_rdy,
    output logic        tx_ok,
    input  logic        din,
    output logic        pkt_valid,
    output logic        pkt_type,
    output logic [1:0]  pkt_hdr,
    output logic [31:0] pkt_payload,
    output logic        crc_err,
    output logic        sync_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES);
    localparam logic [TW-1:0] TMO_PRE  = TW'(TMO_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MID  = BW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [7:0]    CRC_SEED = 8'h88;
    localparam logic [7:0]    CRC_POLY = 8'h4D;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_HUNT  = 3'd2,
        S_SYNC  = 3'd3,
        S_DATA  = 3'd4,
        S_CRC   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    state_t        r_state;
    state_t        w_next_state;
    logic          r_din_q;
    logic [BW-1:0] r_bit_tmr;
    logic [5:0]    r_idx;
    logic [TW-1:0] r_tmo_cnt;
    logic [34:0]   r_shift;
    logic [7:0]    r_crc;
    logic [7:0]    r_rx_crc;

    logic          r_tx_ok;
    logic          r_pkt_valid;
    logic          r_pkt_type;
    logic [1:0]    r_pkt_hdr;
    logic [31:0]   r_pkt_payload;
    logic          r_crc_err;
    logic          r_sync_err;
    logic          r_timeout_err;
    logic          r_busy;

    logic          w_edge;
    logic          w_sample;
    logic          w_sync_exp;
    logic          w_sync_bad;
    logic          w_crc_ok;
    logic          w_tmo_hit;
    logic          w_tmo_pre;
    logic          w_tx_ok_nx;
    logic          w_busy_nx;
    logic          w_tmo_err_nx;
    logic          w_sync_err_nx;
    logic          w_done_nx;
    logic          w_valid_nx;
    logic          w_crc_err_nx;

    assign w_edge     = din & ~r_din_q;
    assign w_sample   = (r_bit_tmr == BIT_MID);
    assign w_sync_exp = ~r_idx[0];
    assign w_sync_bad = (din != w_sync_exp);
    assign w_crc_ok   = ({r_rx_crc[6:0], din} == r_crc);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
    assign w_tmo_pre  = (r_tmo_cnt == TMO_PRE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a low enable aborts from anywhere
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = tx_rdy ? S_GRANT : S_IDLE;
                S_GRANT: w_next_state = S_HUNT;
                S_HUNT: begin
                    if (w_tmo_hit) begin
                        w_next_state = S_IDLE;
                    end else if (w_edge) begin
                        w_next_state = S_SYNC;
                    end else begin
                        w_next_state = S_HUNT;
                    end
                end
                S_SYNC: begin
                    if (w_sample && w_sync_bad) begin
                        w_next_state = S_IDLE;
                    end else if (w_sample && (r_idx == 6'd4)) begin
                        w_next_state = S_DATA;
                    end else begin
                        w_next_state = S_SYNC;
                    end
                end
                S_DATA:  w_next_state = (w_sample && (r_idx == 6'd34)) ? S_CRC : S_DATA;
                S_CRC:   w_next_state = (w_sample && (r_idx == 6'd7)) ? S_DONE : S_CRC;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output decode: pulses are computed a cycle ahead so every output comes from a flop
    always_comb begin
        w_tx_ok_nx    = (w_next_state == S_GRANT);
        w_busy_nx     = (w_next_state != S_IDLE);
        w_tmo_err_nx  = enable && (r_state == S_HUNT) && w_tmo_pre && !w_edge;
        w_sync_err_nx = enable && (r_state == S_SYNC) && w_sample && w_sync_bad;
        w_done_nx     = enable && (r_state == S_CRC) && w_sample && (r_idx == 6'd7);
        w_valid_nx    = w_done_nx && w_crc_ok;
        w_crc_err_nx  = w_done_nx && !w_crc_ok;
    end

    // Datapath: bit timer, indices, shift registers, CRC and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_q       <= 1'b0;
            r_bit_tmr     <= '0;
            r_idx         <= 6'd0;
            r_tmo_cnt     <= '0;
            r_shift       <= 35'd0;
            r_crc         <= 8'h00;
            r_rx_crc      <= 8'h00;
            r_tx_ok       <= 1'b0;
            r_pkt_valid   <= 1'b0;
            r_pkt_type    <= 1'b0;
            r_pkt_hdr     <= 2'd0;
            r_pkt_payload <= 32'd0;
            r_crc_err     <= 1'b0;
            r_sync_err    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_din_q       <= din;
            r_tx_ok       <= w_tx_ok_nx;
            r_busy        <= w_busy_nx;
            r_timeout_err <= w_tmo_err_nx;
            r_sync_err    <= w_sync_err_nx;
            r_pkt_valid   <= w_valid_nx;
            r_crc_err     <= w_crc_err_nx;

            if (w_valid_nx) begin
                r_pkt_type    <= r_shift[34];
                r_pkt_hdr     <= r_shift[33:32];
                r_pkt_payload <= r_shift[31:0];
            end

            if (r_state == S_HUNT) begin
                r_tmo_cnt <= w_tmo_hit ? r_tmo_cnt : r_tmo_cnt + TMO_ONE;
            end else begin
                r_tmo_cnt <= '0;
            end

            // The timer runs free across SYNC/DATA/CRC so the mid-bit phase set by the sync edge is kept
            if ((r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_CRC)) begin
                r_bit_tmr <= (r_bit_tmr == BIT_LAST) ? '0 : r_bit_tmr + BIT_ONE;
            end else begin
                r_bit_tmr <= '0;
            end

            case (r_state)
                S_SYNC: begin
                    if (w_sample) begin
                        r_idx <= (r_idx == 6'd4) ? 6'd0 : r_idx + 6'd1;
                        if (r_idx == 6'd4) begin
                            r_crc <= CRC_SEED;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_idx   <= (r_idx == 6'd34) ? 6'd0 : r_idx + 6'd1;
                        r_shift <= {r_shift[33:0], din};
                        r_crc   <= crc8_step(r_crc, din);
                    end
                end
                S_CRC: begin
                    if (w_sample) begin
                        r_idx    <= r_idx + 6'd1;
                        r_rx_crc <= {r_rx_crc[6:0], din};
                    end
                end
                default: begin
                    r_idx <= 6'd0;
                end
            endcase
        end
    end

    assign tx_ok       = r_tx_ok;
    assign pkt_valid   = r_pkt_valid;
    assign pkt_type    = r_pkt_type;
    assign pkt_hdr     = r_pkt_hdr;
    assign pkt_payload = r_pkt_payload;
    assign crc_err     = r_crc_err;
    assign sync_err    = r_sync_err;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_nm_pkt_rx.sv
// Randomized bench for nm_pkt_rx: frames are decoded by a frame-level model and
// pulse timing is predicted from bit positions in the transmitted stream.
module tb_nm_pkt_rx;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
    localparam int TMO  = 64 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tx_rdy;
    logic        din;
    logic        tx_ok;
    logic        pkt_valid;
    logic        pkt_type;
    logic [1:0]  pkt_hdr;
    logic [31:0] pkt_payload;
    logic        crc_err;
    logic        sync_err;
    logic        timeout_err;
    logic        busy;

    nm_pkt_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tx_rdy(tx_rdy), .tx_ok(tx_ok),
        .din(din), .pkt_valid(pkt_valid), .pkt_type(pkt_type), .pkt_hdr(pkt_hdr),
        .pkt_payload(pkt_payload), .crc_err(crc_err), .sync_err(sync_err),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tx_ok = 0, n_valid = 0, n_crc = 0, n_sync = 0, n_tmo = 0, n_excl = 0;
    int c_valid = 0, c_crc = 0, c_sync = 0;

    always @(negedge clk) begin
        if (tx_ok)     n_tx_ok <= n_tx_ok + 1;
        if (pkt_valid) begin n_valid <= n_valid + 1; c_valid <= cyc; end
        if (crc_err)   begin n_crc   <= n_crc + 1;   c_crc   <= cyc; end
        if (sync_err)  begin n_sync  <= n_sync + 1;  c_sync  <= cyc; end
        if (timeout_err) n_tmo <= n_tmo + 1;
        if (int'(pkt_valid) + int'(crc_err) + int'(sync_err) + int'(timeout_err) > 1)
            n_excl <= n_excl + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [34:0] e_data = 35'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [34:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h88;
        for (int i = 34; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h4D : 8'h00);
        end
        return c;
    endfunction

    // Frame decode: kind 0 good, 1 CRC error, 2 sync error; dbit = stream bit deciding it
    task automatic predict(input logic [55:0] f, output int kind, output int dbit);
        logic [4:0] pat;
        pat  = 5'b10101;
        kind = 0;
        dbit = 55;
        for (int j = 0; j < 5; j++) begin
            if (kind == 0 && f[47 - j] != pat[4 - j]) begin
                kind = 2;
                dbit = 8 + j;
            end
        end
        if (kind == 0 && crc_of(f[42:8]) != f[7:0]) kind = 1;
    endtask

    task automatic wait_grant(output int g);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_ok && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("grant_seen", {63'd0, tx_ok}, 64'd1);
        g = cyc;
    endtask

    function automatic logic [63:0] all_outs();
        return {25'd0, tx_ok, pkt_valid, pkt_type, pkt_hdr, pkt_payload,
                crc_err, sync_err, timeout_err, busy};
    endfunction

    // act: 0 normal, 1 drop enable at bit abit, 2 pulse rst at bit abit
    task automatic run_frame(input logic [55:0] f, input int act, input int abit);
        int kind, dbit, g, exp_cyc;
        int s_tx, s_v, s_c, s_s, s_t;
        predict(f, kind, dbit);
        s_tx = n_tx_ok; s_v = n_valid; s_c = n_crc; s_s = n_sync; s_t = n_tmo;
        tx_rdy = 1'b1;
        wait_grant(g);
        tx_rdy = 1'b0;
        for (int k = 0; k < 56; k++) begin
            din = f[55 - k];
            if (act == 1 && k == abit) begin
                enable = 1'b0;
                repeat (2) @(negedge clk);
                chk("abort_busy", {63'd0, busy}, 64'd0);
                repeat (CPB - 2) @(negedge clk);
                enable = 1'b1;
            end else if (act == 2 && k == abit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_outs", all_outs(), 64'd0);
                e_data = 35'd0;
                repeat (CPB - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        din = 1'b0;
        repeat (4) @(negedge clk);
        exp_cyc = g + CPB * dbit + HALF + 2;
        chk("tx_ok_cnt", 64'(n_tx_ok - s_tx), 64'd1);
        chk("tmo_cnt", 64'(n_tmo - s_t), 64'd0);
        if (act != 0) begin
            chk("abort_pulses", 64'(n_valid - s_v + n_crc - s_c + n_sync - s_s), 64'd0);
        end else begin
            chk("valid_cnt", 64'(n_valid - s_v), (kind == 0) ? 64'd1 : 64'd0);
            chk("crcerr_cnt", 64'(n_crc - s_c), (kind == 1) ? 64'd1 : 64'd0);
            chk("syncerr_cnt", 64'(n_sync - s_s), (kind == 2) ? 64'd1 : 64'd0);
            case (kind)
                0: begin
                    chk("valid_cyc", 64'(c_valid), 64'(exp_cyc));
                    e_data = f[42:8];
                end
                1: chk("crcerr_cyc", 64'(c_crc), 64'(exp_cyc));
                default: chk("syncerr_cyc", 64'(c_sync), 64'(exp_cyc));
            endcase
        end
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("data_out", {29'd0, pkt_type, pkt_hdr, pkt_payload}, {29'd0, e_data});
    endtask

    task automatic run_timeout();
        int g, g2, t, s_tx;
        s_tx = n_tx_ok;
        tx_rdy = 1'b1;
        din = 1'b0;
        wait_grant(g);
        t = 0;
        while (!timeout_err && t < TMO + 100) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_seen", {63'd0, timeout_err}, 64'd1);
        chk("tmo_cyc", 64'(cyc), 64'(g + 1 + TMO));
        @(negedge clk);
        chk("tmo_busy", {63'd0, busy}, 64'd0);
        wait_grant(g2);
        chk("regrant_cyc", 64'(g2), 64'(g + 3 + TMO));
        tx_rdy = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("abort_grant_busy", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("tmo_grants", 64'(n_tx_ok - s_tx), 64'd2);
    endtask

    logic [55:0] fr;
    logic [34:0] d;
    int          sel, idx, s_tx;

    initial begin
        rst = 1'b1; enable = 1'b1; tx_rdy = 1'b0; din = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        enable = 1'b0; tx_rdy = 1'b1;
        s_tx = n_tx_ok;
        repeat (40) @(negedge clk);
        chk("en_low_txok", 64'(n_tx_ok - s_tx), 64'd0);
        chk("en_low_busy", {63'd0, busy}, 64'd0);
        tx_rdy = 1'b0; enable = 1'b1;
        @(negedge clk);

        run_frame({13'b0000000010101, 35'd0, 8'h36}, 0, 0);
        chk("zero_pkt_valid", {63'd0, (c_valid > 0)}, 64'd1);
        d = {$urandom, $urandom};
        run_frame({13'b0000000010101, d, crc_of(d)}, 0, 0);
        run_frame({13'b0000000010101, 35'd0, 8'h37}, 0, 0);
        run_frame({13'b0000000010111, 35'd0, 8'h36}, 0, 0);

        run_timeout();

        d = {$urandom, $urandom};
        run_frame({13'b0000000010101, d, crc_of(d)}, 2, 30);
        run_frame({13'b0000000010101, 35'd0, 8'h36}, 0, 0);
        d = {$urandom, $urandom};
        run_frame({13'b0000000010101, d, crc_of(d)}, 1, 51);

        for (int n = 0; n < 16; n++) begin
            d   = {$urandom, $urandom};
            fr  = {13'b0000000010101, d, crc_of(d)};
            sel = int'($urandom_range(0, 3));
            if (sel == 2) begin
                idx = int'($urandom_range(0, 42));
                fr[idx] = ~fr[idx];
            end else if (sel == 3) begin
                idx = 46 - int'($urandom_range(0, 3));
                fr[idx] = ~fr[idx];
            end
            run_frame(fr, 0, 0);
        end

        chk("pulse_exclusive", 64'(n_excl), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
